// File: rtl/rv_alu_pkg.sv
// Shared constants for the RV32I datapath core: widths and ALU opcodes.
// The register file's write-through forwarding is enabled by RF_BYPASS_EN.
package rv_alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned RF_IDX_W = 5;
  localparam int unsigned OPC_W    = 5;

  localparam logic [OPC_W-1:0] IADD   = 5'd0;
  localparam logic [OPC_W-1:0] ISUB   = 5'd1;
  localparam logic [OPC_W-1:0] ISLL   = 5'd2;
  localparam logic [OPC_W-1:0] ISRL   = 5'd3;
  localparam logic [OPC_W-1:0] ISRA   = 5'd4;
  localparam logic [OPC_W-1:0] IXOR   = 5'd5;
  localparam logic [OPC_W-1:0] IOR    = 5'd6;
  localparam logic [OPC_W-1:0] IAND   = 5'd7;
  localparam logic [OPC_W-1:0] ISLT   = 5'd8;
  localparam logic [OPC_W-1:0] ISLTU  = 5'd9;
  localparam logic [OPC_W-1:0] IEQ    = 5'd10;
  localparam logic [OPC_W-1:0] IPASSB = 5'd11;

  // Zero-extend a single-bit compare result to a full datapath word.
  function automatic logic [XLEN-1:0] flag_to_word(input logic f);
    return {{(XLEN-1){1'b0}}, f};
  endfunction

endpackage

// File: rtl/rv_alu_regfile_rf.sv
// 32x32 register file: two asynchronous reads, one synchronous write, r0 hardwired to 0.
// With RF_BYPASS_EN defined, a same-cycle write is forwarded to matching read ports.
module rv_regfile
  import rv_alu_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [RF_IDX_W-1:0] RNUM1,
  output logic [XLEN-1:0]     RDATA1,
  input  logic [RF_IDX_W-1:0] RNUM2,
  output logic [XLEN-1:0]     RDATA2,
  input  logic [RF_IDX_W-1:0] WNUM,
  input  logic [XLEN-1:0]     WDATA
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_en;

  assign wr_en = (WNUM != RF_IDX_W'(0));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[WNUM] = WDATA;
  end

  // Reset wins over a same-edge write, discarding it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [RF_IDX_W-1:0] rnum);
    logic [XLEN-1:0] rd;
    rd = regs_q[rnum];
`ifdef RF_BYPASS_EN
    if (wr_en && !RST && (rnum == WNUM)) rd = WDATA;
`endif
    if (rnum == RF_IDX_W'(0)) rd = '0;
    return rd;
  endfunction

  assign RDATA1 = read_port(RNUM1);
  assign RDATA2 = read_port(RNUM2);

endmodule

// File: rtl/rv_alu_regfile.sv
// RV32I datapath core: register file for ID plus the combinational EX-stage ALU.
// Optional write-through forwarding in the register file is enabled by RF_BYPASS_EN.
module rv_alu_regfile
  import rv_alu_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [RF_IDX_W-1:0] RNUM1,
  output logic [XLEN-1:0]     RDATA1,
  input  logic [RF_IDX_W-1:0] RNUM2,
  output logic [XLEN-1:0]     RDATA2,
  input  logic [RF_IDX_W-1:0] WNUM,
  input  logic [XLEN-1:0]     WDATA,
  input  logic [XLEN-1:0]     A,
  input  logic [XLEN-1:0]     B,
  input  logic [OPC_W-1:0]    C,
  output logic [XLEN-1:0]     Y,
  output logic                ZERO
);

  rv_regfile u_rf (
    .CLK    (CLK),
    .RST    (RST),
    .RNUM1  (RNUM1),
    .RDATA1 (RDATA1),
    .RNUM2  (RNUM2),
    .RDATA2 (RDATA2),
    .WNUM   (WNUM),
    .WDATA  (WDATA)
  );

  logic [4:0]      shamt;
  logic [XLEN-1:0] y_c;

  assign shamt = B[4:0];

  // Undefined opcodes fall through to the zero default.
  always_comb begin
    y_c = '0;
    case (C)
      IADD:   y_c = A + B;
      ISUB:   y_c = A - B;
      ISLL:   y_c = A << shamt;
      ISRL:   y_c = A >> shamt;
      ISRA:   y_c = XLEN'($signed(A) >>> shamt);
      IXOR:   y_c = A ^ B;
      IOR:    y_c = A | B;
      IAND:   y_c = A & B;
      ISLT:   y_c = flag_to_word($signed(A) < $signed(B));
      ISLTU:  y_c = flag_to_word(A < B);
      IEQ:    y_c = flag_to_word(A == B);
      IPASSB: y_c = B;
      default: y_c = '0;
    endcase
  end

  assign Y    = y_c;
  assign ZERO = (y_c == '0);

endmodule

// File: tb/tb_rv_alu_regfile.sv
// Directed self-checking bench for rv_alu_regfile using an expected-value scoreboard.
module tb_rv_alu_regfile;
  import rv_alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RNUM1, RNUM2, WNUM, C;
  logic [31:0] RDATA1, RDATA2, WDATA, A, B, Y;
  logic        ZERO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;   // 0 RDATA1, 1 RDATA2, 2 Y, 3 ZERO
    logic [31:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  rv_alu_regfile dut (
    .CLK(CLK), .RST(RST),
    .RNUM1(RNUM1), .RDATA1(RDATA1),
    .RNUM2(RNUM2), .RDATA2(RDATA2),
    .WNUM(WNUM), .WDATA(WDATA),
    .A(A), .B(B), .C(C), .Y(Y), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic push(input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.sel = sel; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = RDATA1;
        1:       obs = RDATA2;
        2:       obs = Y;
        default: obs = {31'b0, ZERO};
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive read indices mid-cycle (no write pending) and check both ports.
  task automatic rd(input logic [4:0] n1, input logic [4:0] n2,
                    input logic [31:0] e1, input logic [31:0] e2, input string tag);
    @(negedge CLK);
    RNUM1 = n1; RNUM2 = n2;
    push(0, e1, {tag, "_rd1"});
    push(1, e2, {tag, "_rd2"});
    #2 drain();
  endtask

  task automatic wr(input logic [4:0] n, input logic [31:0] d);
    @(negedge CLK);
    WNUM = n; WDATA = d;
    @(posedge CLK);
    #1 WNUM = 5'd0;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input string tag);
    @(negedge CLK);
    A = a; B = b; C = op;
    push(2, ey, {tag, "_y"});
    push(3, {31'b0, ey == 32'h0}, {tag, "_zero"});
    #2 drain();
  endtask

  // Independent reference for randomized ALU vectors.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    r = 32'h0;
    case (op)
      5'd0:  r = 32'(64'(a) + 64'(b));
      5'd1:  r = a + (~b) + 32'd1;
      5'd2:  r = a * (32'd1 << sh);
      5'd3:  r = a / (32'd1 << sh);
      5'd4:  begin
               r = a;
               for (int k = 0; k < sh; k++) r = {r[31], r[31:1]};
             end
      5'd5:  r = (a | b) & ~(a & b);
      5'd6:  r = ~(~a & ~b);
      5'd7:  r = ~(~a | ~b);
      5'd8:  r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      5'd9:  r = {31'b0, (33'(a) - 33'(b)) >> 32 != 33'd0};
      5'd10: r = {31'b0, (a ^ b) == 32'h0};
      5'd11: r = b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ra, rb, bypass_exp;
    logic [4:0]  rop;
    RST = 1'b1; WNUM = 5'd0; WDATA = 32'h0; RNUM1 = 5'd0; RNUM2 = 5'd0;
    A = 32'h0; B = 32'h0; C = 5'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 32'h0, 32'h0, "reset_clear");

    wr(5'd0, 32'hDEADBEEF);
    rd(5'd0, 5'd0, 32'h0, 32'h0, "r0_hardwired");

    wr(5'd5, 32'h12345678);
    wr(5'd31, 32'hFFFFFFFF);
    rd(5'd5, 5'd31, 32'h12345678, 32'hFFFFFFFF, "r5_r31");
    rd(5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, "same_reg_both");

`ifdef RF_BYPASS_EN
    bypass_exp = 32'hA5A5A5A5;
`else
    bypass_exp = 32'h0;
`endif
    @(negedge CLK);
    WNUM = 5'd7; WDATA = 32'hA5A5A5A5; RNUM1 = 5'd7; RNUM2 = 5'd5;
    push(0, bypass_exp, "same_cycle_r7");
    push(1, 32'h12345678, "same_cycle_other");
    #2 drain();
    @(posedge CLK);
    #1 WNUM = 5'd0;
    rd(5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, "r7_next_cycle");

    alu(IADD,   32'hFFFFFFFF, 32'd1,        32'h0,        "add_wrap");
    alu(ISUB,   32'h0,        32'd1,        32'hFFFFFFFF, "sub_borrow");
    alu(IADD,   32'h7FFFFFFF, 32'd1,        32'h80000000, "add_ovf");
    alu(ISRL,   32'h80000000, 32'h24,       32'h08000000, "srl");
    alu(ISRA,   32'h80000000, 32'h24,       32'hF8000000, "sra");
    alu(ISLL,   32'h1,        32'h24,       32'h00000010, "sll");
    alu(IXOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
    alu(IOR,    32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, "or");
    alu(IAND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
    alu(ISLT,   32'hFFFFFFFF, 32'd1,        32'h1,        "slt");
    alu(ISLTU,  32'hFFFFFFFF, 32'd1,        32'h0,        "sltu");
    alu(IEQ,    32'd5,        32'd5,        32'h1,        "eq");
    alu(IEQ,    32'd5,        32'd6,        32'h0,        "neq");
    alu(IPASSB, 32'hDEAD0000, 32'h12345000, 32'h12345000, "passb");
    alu(5'd31,  32'h1234,     32'h5678,     32'h0,        "undef31");
    alu(5'd12,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        "undef12");

    for (int n = 0; n < 24; n++) begin
      ra = $urandom; rb = $urandom; rop = 5'($urandom_range(0, 15));
      if (n % 6 == 0) rb = 32'hFFFFFFE0 | rb;
      alu(rop, ra, rb, ref_alu(rop, ra, rb), $sformatf("rand%0d_op%0d", n, rop));
    end

    // Reset on the same edge as a write discards it and clears everything.
    @(negedge CLK);
    RST = 1'b1; WNUM = 5'd9; WDATA = 32'h55;
    @(posedge CLK);
    #1 RST = 1'b0; WNUM = 5'd0;
    rd(5'd9, 5'd5, 32'h0, 32'h0, "rst_over_write");
    rd(5'd7, 5'd31, 32'h0, 32'h0, "rst_clears_all");
    wr(5'd9, 32'h66);
    rd(5'd9, 5'd0, 32'h66, 32'h0, "write_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
